// File: rtl/aes_mode_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : aes_mode_ctrl_if
// Description : Bundle of the configuration, block-stream and AES-core
//               handshake signals of the cipher mode controller.
//               master = surrounding system (source, sink and core),
//               slave  = aes_mode_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
interface aes_mode_ctrl_if #(
    parameter int K  = 128,
    parameter int NW = 16
);
    // configuration
    logic           cfg_load;
    logic [K-1:0]   cfg_key;
    logic [127:0]   cfg_iv;
    logic [1:0]     cfg_mode;
    logic           cfg_dir;
    logic           cfg_valid;
    logic           cfg_err;
    // input block stream
    logic           in_valid;
    logic           in_ready;
    logic [127:0]   in_data;
    // output block stream
    logic           out_valid;
    logic           out_ready;
    logic [127:0]   out_data;
    logic [NW-1:0]  blk_count;
    // single-block AES core
    logic           core_load;
    logic [K-1:0]   core_key;
    logic [127:0]   core_in;
    logic           core_dir;
    logic           core_done;
    logic [127:0]   core_out;

    modport master (
        output cfg_load, cfg_key, cfg_iv, cfg_mode, cfg_dir,
        output in_valid, in_data, out_ready, core_done, core_out,
        input  cfg_valid, cfg_err, in_ready, out_valid, out_data, blk_count,
        input  core_load, core_key, core_in, core_dir
    );

    modport slave (
        input  cfg_load, cfg_key, cfg_iv, cfg_mode, cfg_dir,
        input  in_valid, in_data, out_ready, core_done, core_out,
        output cfg_valid, cfg_err, in_ready, out_valid, out_data, blk_count,
        output core_load, core_key, core_in, core_dir
    );
endinterface
`default_nettype wire

// File: rtl/aes_mode_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : aes_mode_ctrl
// Description : Streaming ECB/CBC/CTR mode controller in front of a
//               single-block AES core. One block in flight at a time:
//               IDLE -> LOAD -> WAIT (core busy) -> HOLD (output held).
// Revision    : 1.0 - initial release
// ============================================================================
module aes_mode_ctrl #(
    parameter int K   = 128,
    parameter int INV = 2,
    parameter int CW  = 32,
    parameter int NW  = 16
) (
    input  wire logic       clk,
    input  wire logic       reset,
    aes_mode_ctrl_if.slave  bus
);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_LOAD  = 2'd1;
    localparam logic [1:0] c_ST_WAIT  = 2'd2;
    localparam logic [1:0] c_ST_HOLD  = 2'd3;

    localparam logic [1:0] c_MODE_CBC = 2'd1;
    localparam logic [1:0] c_MODE_CTR = 2'd2;
    localparam logic [1:0] c_MODE_RSV = 2'd3;

    // direction used when the core can only run one way
    localparam logic c_FIXED_DIR = (INV == 1);

    // illegal parameter values stop elaboration
    generate
        if (!(K == 128 || K == 192 || K == 256)) begin : g_bad_k
            $error("aes_mode_ctrl: K must be 128, 192 or 256");
        end
        if (INV < 0 || INV > 2) begin : g_bad_inv
            $error("aes_mode_ctrl: INV must be 0, 1 or 2");
        end
        if (CW < 8 || CW > 128) begin : g_bad_cw
            $error("aes_mode_ctrl: CW must be within 8..128");
        end
    endgenerate

    logic [1:0]    r_state, w_state_next;
    logic          r_cfg_valid, r_cfg_err, r_out_valid, r_core_dir;
    logic [1:0]    r_mode;
    logic [K-1:0]  r_key;
    logic [127:0]  r_chain, r_in, r_core_in, r_out_data;
    logic [NW-1:0] r_blk_count;

    logic          w_in_ready, w_core_load, w_accept, w_cfg_reject, w_eff_dir;
    logic [127:0]  w_ctr_next, w_core_in_next, w_out_next, w_chain_next;

    assign w_eff_dir    = (INV == 2) ? bus.cfg_dir : c_FIXED_DIR;
    assign w_cfg_reject = (bus.cfg_mode == c_MODE_RSV) ||
                          ((bus.cfg_mode == c_MODE_CTR) && (INV == 1));
    assign w_accept     = bus.in_valid && w_in_ready;

    // counter step touches only the low CW bits; upper bits pass through
    generate
        if (CW == 128) begin : g_ctr_full
            assign w_ctr_next = r_chain + 128'd1;
        end else begin : g_ctr_part
            assign w_ctr_next = {r_chain[127:CW], r_chain[CW-1:0] + CW'(1)};
        end
    endgenerate

    // state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: if (w_accept)      w_state_next = c_ST_LOAD;
            c_ST_LOAD:                    w_state_next = c_ST_WAIT;
            c_ST_WAIT: if (bus.core_done) w_state_next = c_ST_HOLD;
            c_ST_HOLD: if (bus.out_ready) w_state_next = c_ST_IDLE;
            default:                      w_state_next = c_ST_IDLE;
        endcase
    end

    // state-decoded outputs; a cfg_load in the same cycle blocks the input
    always_comb begin
        w_in_ready  = 1'b0;
        w_core_load = 1'b0;
        case (r_state)
            c_ST_IDLE: w_in_ready  = r_cfg_valid && !bus.cfg_load;
            c_ST_LOAD: w_core_load = 1'b1;
            default:   ;
        endcase
    end

    // mode chaining: core input at acceptance, result and next chain on done
    always_comb begin
        w_core_in_next = bus.in_data;
        w_out_next     = bus.core_out;
        w_chain_next   = r_chain;
        case (r_mode)
            c_MODE_CBC: begin
                if (!r_core_dir) begin
                    w_core_in_next = bus.in_data ^ r_chain;
                    w_chain_next   = bus.core_out;
                end else begin
                    w_out_next     = bus.core_out ^ r_chain;
                    w_chain_next   = r_in;
                end
            end
            c_MODE_CTR: begin
                w_core_in_next = r_chain;
                w_out_next     = r_in ^ bus.core_out;
                w_chain_next   = w_ctr_next;
            end
            default: ;
        endcase
    end

    // configuration, datapath and block counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cfg_valid <= 1'b0;
            r_cfg_err   <= 1'b0;
            r_out_valid <= 1'b0;
            r_core_dir  <= 1'b0;
            r_mode      <= 2'd0;
            r_key       <= '0;
            r_chain     <= '0;
            r_in        <= '0;
            r_core_in   <= '0;
            r_out_data  <= '0;
            r_blk_count <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (bus.cfg_load) begin
                        r_key       <= bus.cfg_key;
                        r_chain     <= bus.cfg_iv;
                        r_mode      <= bus.cfg_mode;
                        r_core_dir  <= (bus.cfg_mode == c_MODE_CTR) ? 1'b0 : w_eff_dir;
                        r_blk_count <= '0;
                        r_cfg_valid <= !w_cfg_reject;
                        r_cfg_err   <= w_cfg_reject;
                    end else if (w_accept) begin
                        r_in      <= bus.in_data;
                        r_core_in <= w_core_in_next;
                    end
                end
                c_ST_WAIT: begin
                    if (bus.core_done) begin
                        r_out_data  <= w_out_next;
                        r_chain     <= w_chain_next;
                        r_out_valid <= 1'b1;
                    end
                end
                c_ST_HOLD: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_blk_count <= r_blk_count + NW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.cfg_valid = r_cfg_valid;
    assign bus.cfg_err   = r_cfg_err;
    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.blk_count = r_blk_count;
    assign bus.core_load = w_core_load;
    assign bus.core_key  = r_key;
    assign bus.core_in   = r_core_in;
    assign bus.core_dir  = r_core_dir;

endmodule
`default_nettype wire

// File: tb/tb_aes_mode_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_mode_ctrl
// Description : Self-checking bench for aes_mode_ctrl with a table-driven
//               AES core stand-in, a mode-level reference model and a
//               per-cycle output comparator.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_mode_ctrl;
    localparam int K   = 128;
    localparam int INV = 2;
    localparam int CW  = 32;
    localparam int NW  = 4;

    localparam logic [127:0] K1     = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P_ECB  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C_ECB  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K2     = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] IV     = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P1     = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] P2     = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    localparam logic [127:0] C1     = 128'h7649abac8119b246cee98e9b12e9197d;
    localparam logic [127:0] C2     = 128'h5086cb9b507219ee95db113a917678b2;
    localparam logic [127:0] CTR0   = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
    localparam logic [127:0] CTR1   = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdff00;
    localparam logic [127:0] E_CTR  = 128'hec8cdf7398607cb0f2d21675ea9ea1e4;
    localparam logic [127:0] O_CTR  = 128'h874d6191b620e3261bef6864990db6ce;
    localparam logic [127:0] W_IV   = 128'h0123456789abcdef01234567ffffffff;
    localparam logic [127:0] W_NEXT = 128'h0123456789abcdef0123456700000000;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    aes_mode_ctrl_if #(.K(K), .NW(NW)) bus ();

    aes_mode_ctrl #(.K(K), .INV(INV), .CW(CW), .NW(NW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- AES core stand-in: known vectors, else involution ----
    logic [K-1:0]  tbl_key [4];
    logic [127:0]  tbl_pt  [4];
    logic [127:0]  tbl_ct  [4];

    function automatic logic [127:0] core_f(input logic [K-1:0] key,
                                            input logic [127:0] x, input logic dir);
        for (int i = 0; i < 4; i++) begin
            if (key == tbl_key[i] && !dir && x == tbl_pt[i]) return tbl_ct[i];
            if (key == tbl_key[i] &&  dir && x == tbl_ct[i]) return tbl_pt[i];
        end
        return ~x ^ key[127:0];
    endfunction

    int           core_lat = 2;
    int           cm_cnt   = 0;
    logic         cm_done  = 1'b0;
    logic [127:0] cm_out   = '0;
    logic [127:0] cm_in    = '0;
    logic [K-1:0] cm_key   = '0;
    logic         cm_dir   = 1'b0;

    assign bus.core_done = cm_done;
    assign bus.core_out  = cm_out;

    always @(posedge clk) begin
        if (bus.core_load) begin
            cm_done <= 1'b0;
            cm_cnt  <= core_lat;
            cm_in   <= bus.core_in;
            cm_key  <= bus.core_key;
            cm_dir  <= bus.core_dir;
        end else if (cm_cnt > 0) begin
            cm_cnt <= cm_cnt - 1;
            if (cm_cnt == 1) begin
                cm_done <= 1'b1;
                cm_out  <= core_f(cm_key, cm_in, cm_dir);
            end
        end
    end

    // ---------------- reference model state (written by the driver) -------
    logic [K-1:0]  m_key;
    logic [127:0]  m_chain;
    logic [1:0]    m_mode;
    logic          m_dir;
    logic          exp_cfg_valid = 1'b0;
    logic          exp_cfg_err   = 1'b0;
    logic [127:0]  exp_out [64];
    logic [127:0]  exp_cin [64];
    logic          exp_dir [64];
    int            out_wr = 0;
    int            cin_wr = 0;
    int            clr_seq = 0;
    // literal expectations handed to the comparator
    int            lit_seq = 0;
    string         lit_name = "";
    logic [127:0]  lit_act, lit_exp;

    // ---------------- comparator (sole owner of the counts) ---------------
    int            n_tests = 0;
    int            n_fail  = 0;
    int            out_rd = 0;
    int            cin_rd = 0;
    int            clr_seen = 0;
    int            lit_seen = 0;
    logic [NW-1:0] exp_cnt = '0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    initial begin
        logic busy;
        forever begin
            @(negedge clk);
            if (clr_seq != clr_seen) begin
                clr_seen = clr_seq;
                exp_cnt  = '0;
                out_rd   = out_wr;
                cin_rd   = cin_wr;
            end
            if (lit_seq != lit_seen) begin
                lit_seen = lit_seq;
                chk(lit_name, lit_act, lit_exp);
            end
            if (!reset) begin
                busy = (out_rd != out_wr);
                chk("blk_count", 128'(bus.blk_count), 128'(exp_cnt));
                chk("cfg_valid", 128'(bus.cfg_valid), 128'(exp_cfg_valid));
                chk("cfg_err",   128'(bus.cfg_err),   128'(exp_cfg_err));
                chk("in_ready",  128'(bus.in_ready),  128'(!busy && exp_cfg_valid && !bus.cfg_load));
                if (bus.core_load) begin
                    if (cin_rd == cin_wr) begin
                        chk("core_load_unexpected", 128'(1), 128'(0));
                    end else begin
                        chk("core_in",  bus.core_in, exp_cin[cin_rd % 64]);
                        chk("core_dir", 128'(bus.core_dir), 128'(exp_dir[cin_rd % 64]));
                        cin_rd++;
                    end
                end
                if (bus.out_valid) begin
                    if (!busy) begin
                        chk("out_valid_unexpected", 128'(1), 128'(0));
                    end else begin
                        chk("out_data", bus.out_data, exp_out[out_rd % 64]);
                        chk("core_load_while_hold", 128'(bus.core_load), 128'(0));
                        if (bus.out_ready) begin
                            out_rd++;
                            exp_cnt = exp_cnt + NW'(1);
                        end
                    end
                end
            end
        end
    end

    // ---------------- driver helpers --------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic post_lit(input string name, input logic [127:0] act, input logic [127:0] exp);
        lit_name = name;
        lit_act  = act;
        lit_exp  = exp;
        lit_seq++;
        tick();
    endtask

    task automatic model_cfg(input logic [K-1:0] key, input logic [127:0] iv,
                             input logic [1:0] mode, input logic dir);
        m_key         = key;
        m_chain       = iv;
        m_mode        = mode;
        m_dir         = dir;
        exp_cfg_valid = (mode != 2'd3);
        exp_cfg_err   = (mode == 2'd3);
        clr_seq++;
    endtask

    task automatic set_cfg(input logic [K-1:0] key, input logic [127:0] iv,
                           input logic [1:0] mode, input logic dir);
        bus.cfg_key  = key;
        bus.cfg_iv   = iv;
        bus.cfg_mode = mode;
        bus.cfg_dir  = dir;
    endtask

    task automatic do_cfg(input logic [K-1:0] key, input logic [127:0] iv,
                          input logic [1:0] mode, input logic dir);
        set_cfg(key, iv, mode, dir);
        bus.cfg_load = 1'b1;
        tick();
        bus.cfg_load = 1'b0;
        model_cfg(key, iv, mode, dir);
    endtask

    // expected core input and result of one block under the current mode
    task automatic model_block(input logic [127:0] d);
        logic [127:0] cin, out, r;
        logic         dir;
        dir = m_dir;
        case (m_mode)
            2'd1: begin
                if (!m_dir) begin
                    cin = d ^ m_chain; r = core_f(m_key, cin, 1'b0);
                    out = r;           m_chain = r;
                end else begin
                    cin = d;           r = core_f(m_key, d, 1'b1);
                    out = r ^ m_chain; m_chain = d;
                end
            end
            2'd2: begin
                dir = 1'b0;
                cin = m_chain; r = core_f(m_key, cin, 1'b0);
                out = d ^ r;
                m_chain[CW-1:0] = m_chain[CW-1:0] + CW'(1);
            end
            default: begin
                cin = d; out = core_f(m_key, d, m_dir);
            end
        endcase
        exp_cin[cin_wr % 64] = cin;
        exp_dir[cin_wr % 64] = dir;
        exp_out[out_wr % 64] = out;
        cin_wr++;
        out_wr++;
    endtask

    task automatic send_block(input logic [127:0] d, output logic [127:0] cin);
        int t = 0;
        cin = '0;
        while (!bus.in_ready && t < 200) begin tick(); t++; end
        if (!bus.in_ready) begin post_lit("in_ready_timeout", 128'(0), 128'(1)); return; end
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        tick();
        bus.in_valid = 1'b0;
        model_block(d);
        if (!bus.core_load) post_lit("core_load_missing", 128'(0), 128'(1));
        cin = bus.core_in;
    endtask

    task automatic recv_block(output logic [127:0] d);
        int t = 0;
        d = '0;
        while (!bus.out_valid && t < 200) begin tick(); t++; end
        if (!bus.out_valid) begin post_lit("out_valid_timeout", 128'(0), 128'(1)); return; end
        d = bus.out_data;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        exp_cfg_valid = 1'b0;
        exp_cfg_err   = 1'b0;
        clr_seq++;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // ---------------- directed sequence -----------------------------------
    initial begin
        logic [127:0] cin, dout;
        tbl_key[0] = K1; tbl_pt[0] = P_ECB;   tbl_ct[0] = C_ECB;
        tbl_key[1] = K2; tbl_pt[1] = P1 ^ IV; tbl_ct[1] = C1;
        tbl_key[2] = K2; tbl_pt[2] = P2 ^ C1; tbl_ct[2] = C2;
        tbl_key[3] = K2; tbl_pt[3] = CTR0;    tbl_ct[3] = E_CTR;
        bus.cfg_load = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.in_data  = '0;
        set_cfg('0, '0, 2'd0, 1'b0);
        m_key = '0; m_chain = '0; m_mode = 2'd0; m_dir = 1'b0;

        do_reset();
        post_lit("rst_out_data", bus.out_data, 128'(0));
        post_lit("rst_core_in", bus.core_in, 128'(0));
        post_lit("rst_core_dir", 128'(bus.core_dir), 128'(0));

        // ECB encrypt then decrypt
        do_cfg(K1, '0, 2'd0, 1'b0);
        send_block(P_ECB, cin);
        post_lit("ecb_core_in", cin, P_ECB);
        recv_block(dout);
        post_lit("ecb_enc_out", dout, C_ECB);
        post_lit("ecb_blk_count", 128'(bus.blk_count), 128'(1));
        do_cfg(K1, '0, 2'd0, 1'b1);
        send_block(C_ECB, cin);
        recv_block(dout);
        post_lit("ecb_dec_out", dout, P_ECB);

        // CBC encrypt then decrypt
        do_cfg(K2, IV, 2'd1, 1'b0);
        send_block(P1, cin); recv_block(dout); post_lit("cbc_enc_1", dout, C1);
        send_block(P2, cin); recv_block(dout); post_lit("cbc_enc_2", dout, C2);
        do_cfg(K2, IV, 2'd1, 1'b1);
        send_block(C1, cin); recv_block(dout); post_lit("cbc_dec_1", dout, P1);
        send_block(C2, cin); recv_block(dout); post_lit("cbc_dec_2", dout, P2);

        // CTR with cfg_dir=1 still runs the core forward
        do_cfg(K2, CTR0, 2'd2, 1'b1);
        send_block(P1, cin); post_lit("ctr_core_in_0", cin, CTR0);
        recv_block(dout);    post_lit("ctr_out", dout, O_CTR);
        send_block(P2, cin); post_lit("ctr_core_in_1", cin, CTR1);
        recv_block(dout);

        // low-word counter wrap leaves upper bits untouched
        do_cfg(K2, W_IV, 2'd2, 1'b0);
        send_block(P1, cin); recv_block(dout);
        send_block(P2, cin); post_lit("ctr_wrap_core_in", cin, W_NEXT);
        recv_block(dout);

        // output backpressure
        core_lat = 3;
        do_cfg(K1, '0, 2'd0, 1'b0);
        send_block(128'h0badc0de_11111111_22222222_33333333, cin);
        for (int t = 0; t < 200 && !bus.out_valid; t++) tick();
        repeat (10) tick();
        post_lit("bp_out_valid", 128'(bus.out_valid), 128'(1));
        post_lit("bp_in_ready", 128'(bus.in_ready), 128'(0));
        recv_block(dout);
        send_block(P_ECB, cin); recv_block(dout);
        post_lit("bp_next_block", dout, C_ECB);

        // cfg_load while busy is ignored
        send_block(P_ECB, cin);
        set_cfg(K2, IV, 2'd3, 1'b1);
        bus.cfg_load = 1'b1; tick(); bus.cfg_load = 1'b0;
        recv_block(dout);
        post_lit("busy_cfg_ignored_out", dout, C_ECB);
        post_lit("busy_cfg_ignored_err", 128'(bus.cfg_err), 128'(0));

        // cfg_load coincident with an offered block wins
        for (int t = 0; t < 200 && !bus.in_ready; t++) tick();
        set_cfg(K2, IV, 2'd1, 1'b0);
        bus.in_valid = 1'b1; bus.in_data = P2; bus.cfg_load = 1'b1;
        tick();
        bus.in_valid = 1'b0; bus.cfg_load = 1'b0;
        model_cfg(K2, IV, 2'd1, 1'b0);
        post_lit("coincident_no_load", 128'(bus.core_load), 128'(0));
        send_block(P1, cin); recv_block(dout); post_lit("coincident_then_cbc", dout, C1);

        // block counter wraps at 2^NW
        core_lat = 1;
        do_cfg(K2, '0, 2'd0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            send_block({$urandom(), $urandom(), $urandom(), $urandom()}, cin);
            recv_block(dout);
            if (i == 14) post_lit("blk_count_max", 128'(bus.blk_count), 128'(15));
            if (i == 15) post_lit("blk_count_wrap", 128'(bus.blk_count), 128'(0));
        end

        // reserved mode rejected
        do_cfg(K1, IV, 2'd3, 1'b0);
        post_lit("mode3_err", 128'(bus.cfg_err), 128'(1));
        post_lit("mode3_in_ready", 128'(bus.in_ready), 128'(0));

        // reset while waiting on the core; the late core_done is ignored
        core_lat = 8;
        do_cfg(K1, '0, 2'd0, 1'b0);
        send_block(P_ECB, cin);
        tick();
        do_reset();
        repeat (12) tick();
        post_lit("rst_wait_out_valid", 128'(bus.out_valid), 128'(0));
        post_lit("rst_wait_cfg_valid", 128'(bus.cfg_valid), 128'(0));
        post_lit("rst_wait_in_ready", 128'(bus.in_ready), 128'(0));

        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/aes_mode_ctrl.md
Name: aes_mode_ctrl

Overview:
- Streaming block-cipher mode controller that sits between a 128-bit block stream (SPI front-end or DMA) and the single-block AES core.
- Adds ECB, CBC and CTR chaining, IV/counter state, valid/ready flow control on both sides, and a processed-block counter.
- Drives the core through its load/done handshake.
- Successor to the single-shot SPI top level: multi-block, runtime mode-selectable, synchronous reset.

Parameters:
- K, 128, key length in bits; legal values 128/192/256, any other value fails elaboration.
- INV, 2, core capability: 0 encrypt-only, 1 decrypt-only, 2 both.
- CW, 32, CTR increment width: the low CW bits of the 128-bit counter increment; 8..128.
- NW, 16, width of blk_count.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cfg_load  in  1  one-cycle pulse: capture cfg_* (honoured only in IDLE)
- cfg_key  in  K  key
- cfg_iv  in  128  CBC IV or CTR initial counter
- cfg_mode  in  2  0 ECB, 1 CBC, 2 CTR, 3 reserved
- cfg_dir  in  1  0 encrypt, 1 decrypt
- cfg_valid  out  1  configuration accepted
- cfg_err  out  1  last cfg_load rejected
- in_valid / in_ready  in / out  1 / 1  input block handshake
- in_data  in  128  plaintext or ciphertext block
- out_valid / out_ready  out / in  1 / 1  output block handshake
- out_data  out  128  result block
- blk_count  out  NW  blocks output since last accepted cfg_load; wraps mod 2^NW
- core_load  out  1  core load strobe
- core_key  out  K  registered key to core
- core_in  out  128  core input block
- core_dir  out  1  core direction
- core_done  in  1  core result valid; core clears it while core_load=1
- core_out  in  128  core result

Behaviour:
- Reset values:
  - state IDLE
  - cfg_valid, cfg_err, out_valid, core_load = 0
  - out_data, chain, blk_count, core_in = 0
  - core_dir = 0
  - Reset mid-operation abandons the block in flight and ignores subsequent core_done.
- States: IDLE, LOAD, WAIT, HOLD.
  - IDLE: in_ready = cfg_valid. The handshake (in_valid & in_ready) registers core_in and goes to LOAD.
  - LOAD: core_load=1 for exactly one cycle, then WAIT.
  - WAIT: on core_done=1, register out_data, update chain/counter, set out_valid, go to HOLD. No timeout.
  - HOLD: out_valid held, out_data stable; on out_ready, clear out_valid, blk_count+1, go to IDLE.
  - Throughput: at most one block per (4 + core latency) cycles. in_ready=0 outside IDLE.
- cfg_load in IDLE:
  - Capture key; chain = cfg_iv; blk_count = 0.
  - Effective dir: cfg_dir when INV=2, INV otherwise.
  - Reject (cfg_err=1, cfg_valid=0) if mode 3, or if CTR with INV=1. Otherwise cfg_valid=1, cfg_err=0.
  - cfg_load outside IDLE is ignored and no flags change.
  - cfg_load coincident with an input handshake: cfg_load wins, the input is not accepted.
- Datapath, with C = chain register and R = core_out:
  - ECB: core_in = in; out = R.
  - CBC encrypt: core_in = in^C; out = R; C <= R.
  - CBC decrypt: core_in = in; out = R^C; C <= in. The in block is registered at acceptance.
  - CTR: core_dir forced 0; core_in = C; out = in^R; C[CW-1:0] <= C[CW-1:0]+1 mod 2^CW, C[127:CW] unchanged.
- Bit/byte order: bit 127 is the first byte of the block (FIPS-197 order).

Test Plan:
- ECB enc, K=128, key 000102030405060708090a0b0c0d0e0f, in 00112233445566778899aabbccddeeff -> out 69c4e0d86a7b0430d8cdb78070b4c55a, blk_count=1; decrypt of that output returns the plaintext.
- CBC enc, key 2b7e151628aed2a6abf7158809cf4f3c, IV 000102..0f, blocks 6bc1bee22e409f96e93d7e117393172a, ae2d8a571e03ac9c9eb76fac45af8e51 -> 7649abac8119b246cee98e9b12e9197d, 5086cb9b507219ee95db113a917678b2; CBC decrypt of those returns the plaintext.
- CTR, same key, counter f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff, block 6bc1bee2... -> 874d6191b620e3261bef6864990db6ce. Counter becomes ...fcfdff00 in the low 32 bits, with bits above CW=32 unchanged.
- Wrap: IV low word ffffffff, CW=32 -> after one block C = IV with low word 00000000; blk_count at 2^NW-1 wraps to 0.
- Backpressure: out_ready=0 for 10 cycles -> out_valid and out_data stable, in_ready=0, no core_load; after release, the next block proceeds normally.
- Errors/reset: cfg_mode=3 -> cfg_err=1, in_ready=0. Reset during WAIT, then core_done -> out_valid stays 0, state IDLE, cfg_valid=0.
